// File: rtl/axi_grid_tni.sv
// Target-side grid network interface for the write path. It unpacks request packets from the
// router into AXI4 AW/W and packs each B response into a flit routed back to the source node.
module axi_grid_tni #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned NODE_WIDTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned FLIT_WIDTH     = DATA_WIDTH + DATA_WIDTH / 8,
  localparam int unsigned RSP_WIDTH      = NODE_WIDTH + ID_WIDTH + 2
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic [FLIT_WIDTH-1:0]   req_flit_i,
  input  logic                    req_flit_valid_i,
  output logic                    req_flit_ready_o,
  output logic [ID_WIDTH-1:0]     m_aw_id_o,
  output logic [ADDR_WIDTH-1:0]   m_aw_addr_o,
  output logic [7:0]              m_aw_len_o,
  output logic [2:0]              m_aw_size_o,
  output logic [1:0]              m_aw_burst_o,
  output logic                    m_aw_valid_o,
  input  logic                    m_aw_ready_i,
  output logic [DATA_WIDTH-1:0]   m_w_data_o,
  output logic [DATA_WIDTH/8-1:0] m_w_strb_o,
  output logic                    m_w_last_o,
  output logic                    m_w_valid_o,
  input  logic                    m_w_ready_i,
  input  logic [ID_WIDTH-1:0]     m_b_id_i,
  input  logic [1:0]              m_b_resp_i,
  input  logic                    m_b_valid_i,
  output logic                    m_b_ready_o,
  output logic [RSP_WIDTH-1:0]    rsp_flit_o,
  output logic                    rsp_flit_valid_o,
  input  logic                    rsp_flit_ready_i
);

  localparam int unsigned NumIds   = 2 ** ID_WIDTH;
  localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned LenLsb   = ADDR_WIDTH;
  localparam int unsigned SizeLsb  = ADDR_WIDTH + 8;
  localparam int unsigned BurstLsb = ADDR_WIDTH + 11;
  localparam int unsigned IdLsb    = ADDR_WIDTH + 13;
  localparam int unsigned SrcLsb   = IdLsb + ID_WIDTH;

  typedef enum logic [1:0] {StIdle, StAw, StData} state_e;

  state_e                state_q, state_d;
  logic                  init_q;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]            aw_len_q, aw_len_d;
  logic [2:0]            aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic [7:0]            beat_q, beat_d;
  logic [CntWidth-1:0]   cnt_q [NumIds];
  logic [CntWidth-1:0]   cnt_d [NumIds];
  logic [NODE_WIDTH-1:0] src_q [NumIds];
  logic [NODE_WIDTH-1:0] src_d [NumIds];
  logic                  rsp_valid_q, rsp_valid_d;
  logic [RSP_WIDTH-1:0]  rsp_flit_q, rsp_flit_d;

  logic [ID_WIDTH-1:0]   hdr_id;
  logic [NODE_WIDTH-1:0] hdr_src;
  logic [CntWidth-1:0]   hdr_cnt;
  logic                  hdr_stall, hdr_hs, aw_hs, w_hs, b_hs;

  assign hdr_id    = req_flit_i[IdLsb +: ID_WIDTH];
  assign hdr_src   = req_flit_i[SrcLsb +: NODE_WIDTH];
  assign hdr_cnt   = cnt_q[hdr_id];
  // An ID may only be reused by another source once all its writes have completed.
  assign hdr_stall = (hdr_cnt == CntWidth'(MAX_OUTSTANDING)) ||
                     ((hdr_cnt != '0) && (src_q[hdr_id] != hdr_src));

  assign hdr_hs = (state_q == StIdle) && req_flit_valid_i && req_flit_ready_o;
  assign aw_hs  = m_aw_valid_o && m_aw_ready_i;
  assign w_hs   = m_w_valid_o && m_w_ready_i;
  assign b_hs   = m_b_valid_i && m_b_ready_o;

  assign m_aw_id_o        = aw_id_q;
  assign m_aw_addr_o      = aw_addr_q;
  assign m_aw_len_o       = aw_len_q;
  assign m_aw_size_o      = aw_size_q;
  assign m_aw_burst_o     = aw_burst_q;
  assign m_aw_valid_o     = (state_q == StAw);
  assign m_w_data_o       = req_flit_i[DATA_WIDTH-1:0];
  assign m_w_strb_o       = req_flit_i[FLIT_WIDTH-1:DATA_WIDTH];
  assign m_w_last_o       = (state_q == StData) && (beat_q == aw_len_q);
  assign m_b_ready_o      = !rsp_valid_q || rsp_flit_ready_i;
  assign rsp_flit_o       = rsp_flit_q;
  assign rsp_flit_valid_o = rsp_valid_q;

  always_comb begin
    req_flit_ready_o = 1'b0;
    m_w_valid_o      = 1'b0;
    unique case (state_q)
      StIdle: req_flit_ready_o = init_q && !hdr_stall;
      StData: begin
        req_flit_ready_o = m_w_ready_i;
        m_w_valid_o      = req_flit_valid_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    beat_d     = beat_q;
    unique case (state_q)
      StIdle: begin
        if (hdr_hs) begin
          aw_addr_d  = req_flit_i[ADDR_WIDTH-1:0];
          aw_len_d   = req_flit_i[LenLsb +: 8];
          aw_size_d  = req_flit_i[SizeLsb +: 3];
          aw_burst_d = req_flit_i[BurstLsb +: 2];
          aw_id_d    = hdr_id;
          state_d    = StAw;
        end
      end
      StAw: begin
        if (aw_hs) begin
          beat_d  = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          if (m_w_last_o) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int i = 0; i < int'(NumIds); i++) begin
      cnt_d[i] = cnt_q[i];
      src_d[i] = src_q[i];
      if (aw_hs && (aw_id_q == ID_WIDTH'(i))) cnt_d[i] = cnt_d[i] + CntWidth'(1);
      if (b_hs && (m_b_id_i == ID_WIDTH'(i)) && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_d[i] - CntWidth'(1);
      end
      if (hdr_hs && (hdr_cnt == '0) && (hdr_id == ID_WIDTH'(i))) src_d[i] = hdr_src;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_flit_d  = rsp_flit_q;
    if (b_hs) begin
      rsp_valid_d = 1'b1;
      rsp_flit_d  = {src_q[m_b_id_i], m_b_id_i, m_b_resp_i};
    end else if (rsp_flit_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= StIdle;
      init_q      <= 1'b0;
      aw_id_q     <= '0;
      aw_addr_q   <= '0;
      aw_len_q    <= '0;
      aw_size_q   <= '0;
      aw_burst_q  <= '0;
      beat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_flit_q  <= '0;
      for (int i = 0; i < int'(NumIds); i++) begin
        cnt_q[i] <= '0;
        src_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      init_q      <= 1'b1;
      aw_id_q     <= aw_id_d;
      aw_addr_q   <= aw_addr_d;
      aw_len_q    <= aw_len_d;
      aw_size_q   <= aw_size_d;
      aw_burst_q  <= aw_burst_d;
      beat_q      <= beat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_flit_q  <= rsp_flit_d;
      for (int i = 0; i < int'(NumIds); i++) begin
        cnt_q[i] <= cnt_d[i];
        src_q[i] <= src_d[i];
      end
    end
  end

  // A B response for an ID with nothing outstanding is a subordinate protocol error.
  b_for_idle_id_a: assert property (@(posedge clk_i) disable iff (!arst_ni)
    b_hs |-> (cnt_q[m_b_id_i] != '0));

endmodule

// File: tb/tb_axi_grid_tni.sv
// Scoreboard bench for axi_grid_tni: the bench plays router and AXI subordinate, predicting each
// AW, W beat and response flit from the packets it sends and the B responses it returns.
module tb_axi_grid_tni;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int NW = 4;
  localparam int FW = DW + DW / 8;
  localparam int RW = NW + IW + 2;
  localparam int LIMIT = 500;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic [IW-1:0] id;
    logic [NW-1:0] src;
  } pkt_t;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic            last;
  } beat_t;

  typedef struct packed {
    int          c;
    logic [RW-1:0] f;
  } lat_t;

  logic clk = 1'b0;
  logic arst_ni = 1'b0;
  logic [FW-1:0] req_flit_i = '0;
  logic req_flit_valid_i = 1'b0;
  logic req_flit_ready_o;
  logic [IW-1:0] m_aw_id_o;
  logic [AW-1:0] m_aw_addr_o;
  logic [7:0] m_aw_len_o;
  logic [2:0] m_aw_size_o;
  logic [1:0] m_aw_burst_o;
  logic m_aw_valid_o;
  logic m_aw_ready_i = 1'b1;
  logic [DW-1:0] m_w_data_o;
  logic [DW/8-1:0] m_w_strb_o;
  logic m_w_last_o, m_w_valid_o;
  logic m_w_ready_i = 1'b1;
  logic [IW-1:0] m_b_id_i = '0;
  logic [1:0] m_b_resp_i = '0;
  logic m_b_valid_i = 1'b0;
  logic m_b_ready_o;
  logic [RW-1:0] rsp_flit_o;
  logic rsp_flit_valid_o;
  logic rsp_flit_ready_i = 1'b1;

  axi_grid_tni dut (
    .clk_i(clk), .arst_ni(arst_ni),
    .req_flit_i(req_flit_i), .req_flit_valid_i(req_flit_valid_i),
    .req_flit_ready_o(req_flit_ready_o),
    .m_aw_id_o(m_aw_id_o), .m_aw_addr_o(m_aw_addr_o), .m_aw_len_o(m_aw_len_o),
    .m_aw_size_o(m_aw_size_o), .m_aw_burst_o(m_aw_burst_o), .m_aw_valid_o(m_aw_valid_o),
    .m_aw_ready_i(m_aw_ready_i),
    .m_w_data_o(m_w_data_o), .m_w_strb_o(m_w_strb_o), .m_w_last_o(m_w_last_o),
    .m_w_valid_o(m_w_valid_o), .m_w_ready_i(m_w_ready_i),
    .m_b_id_i(m_b_id_i), .m_b_resp_i(m_b_resp_i), .m_b_valid_i(m_b_valid_i),
    .m_b_ready_o(m_b_ready_o),
    .rsp_flit_o(rsp_flit_o), .rsp_flit_valid_o(rsp_flit_valid_o),
    .rsp_flit_ready_i(rsp_flit_ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hdr_wait = 0;
  int w_total = 0;
  int rdy_mode = 0;
  bit b_auto = 1'b0;
  bit b_busy = 1'b0;
  bit drv_busy = 1'b0;
  bit abort = 1'b0;
  bit in_data = 1'b0;

  pkt_t aw_exp[$];
  pkt_t wr_active[$];
  pkt_t done_q[$];
  beat_t w_exp[$];
  logic [RW-1:0] rsp_exp[$];
  lat_t lat_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [AW-1:0] addr, input int len, input int size,
                              input int burst, input int id, input int src);
    pkt_t p;
    p.addr = addr; p.len = 8'(len); p.size = 3'(size); p.burst = 2'(burst);
    p.id = IW'(id); p.src = NW'(src);
    return p;
  endfunction

  // Waits for req_flit_ready_o on the presented flit; returns after the accepting edge.
  task automatic wait_rdy(output bit ok, output int n);
    ok = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (abort) return;
      if (req_flit_ready_o) begin
        ok = 1'b1;
        @(posedge clk); #1;
        return;
      end
      n++;
      if (n > LIMIT) begin
        checks++; errors++;
        $display("FAIL req_accept_timeout actual=%0d required=%0d", n, LIMIT);
        return;
      end
    end
  endtask

  task automatic send_packet(input pkt_t p, input bit gaps);
    logic [FW-1:0] hdr;
    logic [FW-1:0] flits[$];
    beat_t b;
    bit ok;
    int n;
    drv_busy = 1'b1;
    hdr = '0;
    hdr[AW-1:0] = p.addr;
    hdr[AW +: 8] = p.len;
    hdr[AW+8 +: 3] = p.size;
    hdr[AW+11 +: 2] = p.burst;
    hdr[AW+13 +: IW] = p.id;
    hdr[AW+13+IW +: NW] = p.src;
    @(posedge clk); #1;
    req_flit_i = hdr;
    req_flit_valid_i = 1'b1;
    wait_rdy(ok, n);
    hdr_wait = n;
    if (ok) begin
      aw_exp.push_back(p);
      for (int i = 0; i <= int'(p.len); i++) begin
        b.data = {$urandom, $urandom};
        b.strb = 8'($urandom);
        b.last = (i == int'(p.len));
        w_exp.push_back(b);
        flits.push_back({b.strb, b.data});
      end
      foreach (flits[i]) begin
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            req_flit_valid_i = 1'b0;
            @(posedge clk); #1;
          end
        end
        req_flit_i = flits[i];
        req_flit_valid_i = 1'b1;
        wait_rdy(ok, n);
        if (!ok) break;
      end
    end
    req_flit_valid_i = 1'b0;
    drv_busy = 1'b0;
  endtask

  // Returns the oldest completed write's B; call aligned just after a rising edge.
  task automatic drive_b(input logic [1:0] resp);
    pkt_t r;
    int n;
    lat_t l;
    if (done_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL b_nothing_done actual=0 required=1");
      return;
    end
    r = done_q.pop_front();
    m_b_id_i = r.id;
    m_b_resp_i = resp;
    m_b_valid_i = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (m_b_ready_o) begin
        rsp_exp.push_back({r.src, r.id, resp});
        l.c = cyc + 1;
        l.f = {r.src, r.id, resp};
        lat_q.push_back(l);
        break;
      end
      n++;
      if (n > LIMIT) begin
        checks++; errors++;
        $display("FAIL b_ready_timeout actual=%0d required=%0d", n, LIMIT);
        break;
      end
    end
    @(posedge clk); #1;
    m_b_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((drv_busy || b_busy) && n <= LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n > LIMIT, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((drv_busy || b_busy || done_q.size() != 0 || rsp_exp.size() != 0) && n <= 4 * LIMIT)
    begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n > 4 * LIMIT, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) begin
      m_aw_ready_i = 1'($urandom_range(0, 1));
      m_w_ready_i = 1'($urandom_range(0, 1));
      rsp_flit_ready_i = ($urandom_range(0, 3) != 0);
    end else if (rdy_mode == 2) begin
      m_w_ready_i = !m_w_ready_i;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (b_auto && arst_ni && done_q.size() > 0 && $urandom_range(0, 1) == 0) begin
        b_busy = 1'b1;
        drive_b(2'($urandom_range(0, 3)));
        b_busy = 1'b0;
      end
    end
  end

  // Monitor: every output handshake pops and compares the scoreboard queues.
  always @(negedge clk) begin
    pkt_t p;
    beat_t b;
    if (!arst_ni) begin
      in_data = 1'b0;
    end else begin
      if (in_data) begin
        chk("w_ready_passthru", req_flit_ready_o, m_w_ready_i);
        chk("w_valid_passthru", m_w_valid_o, req_flit_valid_i);
      end else begin
        chk("w_valid_outside_burst", m_w_valid_o, 1'b0);
      end
      if (lat_q.size() > 0 && lat_q[0].c == cyc) begin
        chk("rsp_latency_valid", rsp_flit_valid_o, 1'b1);
        chk("rsp_latency_flit", rsp_flit_o, lat_q[0].f);
        void'(lat_q.pop_front());
      end
      if (m_w_valid_o && m_w_ready_i) begin
        w_total++;
        if (w_exp.size() == 0) begin
          chk("w_unexpected", 1'b1, 1'b0);
        end else begin
          b = w_exp.pop_front();
          chk("w_beat", {m_w_data_o, m_w_strb_o, m_w_last_o}, b);
          if (b.last) begin
            in_data = 1'b0;
            if (wr_active.size() > 0) done_q.push_back(wr_active.pop_front());
          end
        end
      end
      if (m_aw_valid_o && m_aw_ready_i) begin
        if (aw_exp.size() == 0) begin
          chk("aw_unexpected", 1'b1, 1'b0);
        end else begin
          p = aw_exp.pop_front();
          chk("aw_fields", {m_aw_id_o, m_aw_addr_o, m_aw_len_o, m_aw_size_o, m_aw_burst_o},
              {p.id, p.addr, p.len, p.size, p.burst});
          wr_active.push_back(p);
          in_data = 1'b1;
        end
      end
      if (rsp_flit_valid_o && rsp_flit_ready_i) begin
        if (rsp_exp.size() == 0) chk("rsp_unexpected", 1'b1, 1'b0);
        else chk("rsp_flit", rsp_flit_o, rsp_exp.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=%0d required<%0d", cyc, cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t p;
    int n;
    int base;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_flit_ready_o, 1'b0);
    chk("rst_aw_valid", m_aw_valid_o, 1'b0);
    chk("rst_w_valid", m_w_valid_o, 1'b0);
    chk("rst_rsp_valid", rsp_flit_valid_o, 1'b0);
    chk("rst_aw_fields", {m_aw_id_o, m_aw_addr_o, m_aw_len_o, m_aw_size_o, m_aw_burst_o}, '0);
    chk("rst_rsp_flit", rsp_flit_o, '0);
    arst_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single write: AW follows the header by one cycle, response routed to node 5.
    p = mk(32'h1000, 0, 3, 1, 2, 5);
    fork send_packet(p, 1'b0); join_none
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(req_flit_valid_i && req_flit_ready_o) && n < 20);
    @(negedge clk);
    chk("single_aw_next_cycle", m_aw_valid_o, 1'b1);
    chk("single_aw_addr", m_aw_addr_o, 32'h1000);
    wait_idle("single_idle");
    chk("single_done", done_q.size(), 1);
    drive_b(2'b00);
    @(negedge clk);
    chk("single_rsp_flit", {rsp_flit_valid_o, rsp_flit_o}, {1'b1, 10'h148});
    p = mk(32'h2000, 0, 3, 1, 2, 9);
    send_packet(p, 1'b0);
    chk("single_cnt_cleared", hdr_wait, 0);
    wait_idle("single2_idle");
    drive_b(2'b01);

    // 4-beat burst with W ready toggling every cycle.
    rdy_mode = 2;
    p = mk(32'h3000, 3, 3, 1, 4, 1);
    send_packet(p, 1'b0);
    rdy_mode = 0;
    m_w_ready_i = 1'b1;
    chk("toggle_all_beats", w_exp.size(), 0);
    chk("toggle_completed", done_q.size(), 1);
    drive_b(2'b00);
    p = mk(32'h3100, 0, 2, 1, 6, 1);
    send_packet(p, 1'b0);
    chk("toggle_back_to_idle", hdr_wait, 0);
    wait_idle("toggle_idle");
    drive_b(2'b00);

    // Response backpressure with two B responses pending.
    send_packet(mk(32'h4000, 1, 3, 1, 0, 4), 1'b0);
    send_packet(mk(32'h4100, 0, 3, 1, 3, 6), 1'b0);
    wait_idle("bp_idle");
    rsp_flit_ready_i = 1'b0;
    drive_b(2'b00);
    @(negedge clk);
    chk("bp_b_ready_drop", m_b_ready_o, 1'b0);
    fork begin b_busy = 1'b1; drive_b(2'b10); b_busy = 1'b0; end join_none
    repeat (2) @(negedge clk);
    chk("bp_b_ready_held", m_b_ready_o, 1'b0);
    chk("bp_rsp_held", rsp_flit_valid_o, 1'b1);
    @(posedge clk); #1;
    rsp_flit_ready_i = 1'b1;
    wait_idle("bp_b_idle");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_both_delivered", rsp_exp.size(), 0);

    // Same ID from another source stalls until its outstanding write completes.
    send_packet(mk(32'h5000, 0, 3, 1, 1, 3), 1'b0);
    wait_idle("src_first_idle");
    fork send_packet(mk(32'h5100, 1, 3, 1, 1, 7), 1'b0); join_none
    repeat (6) @(negedge clk);
    chk("src_stall", req_flit_ready_o, 1'b0);
    @(posedge clk); #1;
    drive_b(2'b00);
    wait_idle("src_second_idle");
    chk("src_waited", hdr_wait >= 6, 1'b1);
    drive_b(2'b00);

    // Outstanding limit, then a B and an AW handshake on id 0 in the same cycle.
    for (int i = 0; i < 4; i++) send_packet(mk(32'h6000 + 32'(i * 64), i, 3, 1, 0, 2), 1'b0);
    wait_idle("lim_fill_idle");
    fork send_packet(mk(32'h6400, 1, 3, 1, 0, 2), 1'b0); join_none
    repeat (5) @(negedge clk);
    chk("lim_fifth_stalls", req_flit_ready_o, 1'b0);
    @(posedge clk); #1;
    m_aw_ready_i = 1'b0;
    drive_b(2'b00);
    n = 0;
    while (!m_aw_valid_o && n < 20) begin @(negedge clk); n++; end
    chk("lim_fifth_aw", m_aw_valid_o, 1'b1);
    @(posedge clk); #1;
    m_aw_ready_i = 1'b1;
    drive_b(2'b00);
    wait_idle("lim_fifth_idle");
    send_packet(mk(32'h6500, 0, 3, 1, 0, 2), 1'b0);
    chk("lim_sixth_accepts", hdr_wait, 0);
    wait_idle("lim_sixth_idle");
    fork send_packet(mk(32'h6600, 0, 3, 1, 0, 2), 1'b0); join_none
    repeat (5) @(negedge clk);
    chk("lim_seventh_stalls", req_flit_ready_o, 1'b0);
    b_auto = 1'b1;
    wait_drain("lim_drain");
    b_auto = 1'b0;
    wait_idle("lim_b_idle");

    // Reset during the data phase of a 4-beat burst.
    send_packet(mk(32'h7000, 0, 3, 1, 1, 3), 1'b0);
    base = w_total;
    fork send_packet(mk(32'h7100, 3, 3, 1, 2, 8), 1'b0); join_none
    n = 0;
    while (w_total < base + 2 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #2;
    abort = 1'b1;
    arst_ni = 1'b0;
    #1;
    chk("rstd_req_ready", req_flit_ready_o, 1'b0);
    chk("rstd_valids", {m_aw_valid_o, m_w_valid_o, rsp_flit_valid_o}, 3'b000);
    chk("rstd_aw_addr", m_aw_addr_o, '0);
    wait_idle("rstd_drv_idle");
    aw_exp.delete(); wr_active.delete(); done_q.delete(); w_exp.delete();
    rsp_exp.delete(); lat_q.delete();
    repeat (2) @(posedge clk);
    #3;
    arst_ni = 1'b1;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_packet(mk(32'h7200, 0, 3, 1, 1, 9), 1'b0);
    chk("rstd_counters_clear", hdr_wait, 0);
    wait_idle("rstd_idle");

    // Randomised traffic with random readiness and B timing.
    rdy_mode = 1;
    b_auto = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_packet(mk({$urandom}, $urandom_range(0, 7), $urandom_range(0, 3),
                     $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 15)), 1'b1);
    end
    rdy_mode = 0;
    m_aw_ready_i = 1'b1;
    m_w_ready_i = 1'b1;
    rsp_flit_ready_i = 1'b1;
    wait_drain("rand_drain");
    repeat (3) @(posedge clk);
    #1;
    chk("end_aw_empty", aw_exp.size(), 0);
    chk("end_w_empty", w_exp.size(), 0);
    chk("end_rsp_empty", rsp_exp.size(), 0);
    chk("end_rsp_valid", rsp_flit_valid_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
